// File: rtl/riscv_exec_trace_buf_if.sv
// Reader-side bundle of the EX trace buffer: FIFO head entry plus valid/ready handshake.
// The buffer drives the master side; the debug/testbench reader uses the slave side.
interface riscv_exec_trace_buf_if #(
    parameter int XLEN = 32,
    parameter int TS_W = 16
) ();
    logic            rd_valid;
    logic            rd_ready;
    logic [TS_W-1:0] rd_ts;
    logic [XLEN-1:0] rd_pc;
    logic [31:0]     rd_instr;
    logic [6:0]      rd_flags;

    modport master (output rd_valid, rd_ts, rd_pc, rd_instr, rd_flags, input rd_ready);
    modport slave  (input rd_valid, rd_ts, rd_pc, rd_instr, rd_flags, output rd_ready);
endinterface

// File: rtl/riscv_exec_trace_buf.sv
// EX-stage trace capture: timestamped FIFO of qualifying execute-stage cycles,
// saturating hazard/forwarding event counters and a sticky drop flag.
module riscv_exec_trace_buf #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int TS_W        = 16,
    parameter int CNT_W       = 16,
    parameter int MODE        = 0,
    parameter int STALL_DEDUP = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid,
    input  logic [31:0]            instr,
    input  logic [XLEN-1:0]        pc,
    input  logic [1:0]             forward_a,
    input  logic [1:0]             forward_b,
    input  logic                   stall_if,
    input  logic                   flush_ex,
    input  logic                   redirect_valid,
    input  logic                   clear,
    riscv_exec_trace_buf_if.master rd,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt,
    output logic [CNT_W-1:0]       redir_cnt,
    output logic [CNT_W-1:0]       fwd_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [6:0]      flags;
    } entry_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        logic [CNT_W-1:0] r;
        if (en && (c != {CNT_W{1'b1}})) r = c + CNT_W'(1);
        else                            r = c;
        return r;
    endfunction

    entry_t            mem_r [DEPTH];
    entry_t            head_r;
    entry_t            head_nxt_s;
    entry_t            new_entry_s;
    logic              head_valid_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW-1:0]     rd_ptr_nxt_s;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_nxt_s;
    logic [TS_W-1:0]   ts_r;
    logic              hist_valid_r;
    logic [XLEN-1:0]   hist_pc_r;
    logic [31:0]       hist_instr_r;
    logic              overflow_r;
    logic [CNT_W-1:0]  drop_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;
    logic [CNT_W-1:0]  redir_cnt_r;
    logic [CNT_W-1:0]  fwd_cnt_r;
    logic              event_s;
    logic              fwd_any_s;
    logic              dup_s;
    logic              capture_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;

    // Capture qualification, FIFO push/pop decisions and the next head entry.
    always_comb begin
        fwd_any_s   = (forward_a != 2'b00) || (forward_b != 2'b00);
        event_s     = stall_if || flush_ex || redirect_valid || fwd_any_s;
        dup_s       = (STALL_DEDUP != 0) && stall_if && hist_valid_r &&
                      (pc == hist_pc_r) && (instr == hist_instr_r);
        capture_s   = valid && ((MODE == 0) || event_s) && !dup_s;
        full_s      = (count_r == CW'(DEPTH));
        pop_s       = head_valid_r && rd.rd_ready;
        push_s      = capture_s && (!full_s || pop_s);
        drop_s      = capture_s && full_s && !pop_s;
        new_entry_s = '{ts: ts_r, pc: pc, instr: instr,
                        flags: {redirect_valid, flush_ex, stall_if, forward_b, forward_a}};

        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase

        rd_ptr_nxt_s = rd_ptr_r;
        if (pop_s) rd_ptr_nxt_s = rd_ptr_r + AW'(1);
        else       rd_ptr_nxt_s = rd_ptr_r;

        // The entry written this edge is not in mem_r yet, so bypass it when it becomes the head.
        head_nxt_s = '0;
        if (count_nxt_s == '0)                              head_nxt_s = '0;
        else if (push_s && (wr_ptr_r == rd_ptr_nxt_s))      head_nxt_s = new_entry_s;
        else                                                head_nxt_s = mem_r[rd_ptr_nxt_s];
    end

    // Free-running timestamp; only a hard reset restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) ts_r <= '0;
        else        ts_r <= ts_r + TS_W'(1);
    end

    // FIFO storage; no reset needed because reads are gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (rst_n && !clear && push_s) mem_r[wr_ptr_r] <= new_entry_s;
    end

    // FIFO control, registered head, dedup history and event counters.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            head_r       <= '0;
            head_valid_r <= 1'b0;
            hist_valid_r <= 1'b0;
            hist_pc_r    <= '0;
            hist_instr_r <= '0;
            overflow_r   <= 1'b0;
            drop_cnt_r   <= '0;
            stall_cnt_r  <= '0;
            flush_cnt_r  <= '0;
            redir_cnt_r  <= '0;
            fwd_cnt_r    <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            rd_ptr_r     <= rd_ptr_nxt_s;
            count_r      <= count_nxt_s;
            head_r       <= head_nxt_s;
            head_valid_r <= (count_nxt_s != '0);
            if (capture_s) begin
                hist_pc_r    <= pc;
                hist_instr_r <= instr;
            end
            // Dedup only spans an unbroken stall; any unstalled cycle forgets the history.
            hist_valid_r <= stall_if ? (hist_valid_r || capture_s) : 1'b0;
            overflow_r   <= overflow_r || drop_s;
            drop_cnt_r   <= sat_inc(drop_cnt_r, drop_s);
            stall_cnt_r  <= sat_inc(stall_cnt_r, valid && stall_if);
            flush_cnt_r  <= sat_inc(flush_cnt_r, valid && flush_ex);
            redir_cnt_r  <= sat_inc(redir_cnt_r, valid && redirect_valid);
            fwd_cnt_r    <= sat_inc(fwd_cnt_r, valid && fwd_any_s);
        end
    end

    assign rd.rd_valid = head_valid_r;
    assign rd.rd_ts    = head_r.ts;
    assign rd.rd_pc    = head_r.pc;
    assign rd.rd_instr = head_r.instr;
    assign rd.rd_flags = head_r.flags;
    assign count       = count_r;
    assign overflow    = overflow_r;
    assign drop_cnt    = drop_cnt_r;
    assign stall_cnt   = stall_cnt_r;
    assign flush_cnt   = flush_cnt_r;
    assign redir_cnt   = redir_cnt_r;
    assign fwd_cnt     = fwd_cnt_r;
endmodule

// File: tb/tb_riscv_exec_trace_buf.sv
// Directed bench for riscv_exec_trace_buf: four parameter variants share the EX stimulus,
// each with its own reader handshake.
module tb_riscv_exec_trace_buf;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic        stall_if;
    logic        flush_ex;
    logic        redirect_valid;
    logic        clear;
    logic [31:0] tcount;
    int          tests = 0;
    int          failures = 0;

    logic [4:0]  count_a, count_b, count_c, count_d;
    logic        ovf_a, ovf_b, ovf_c, ovf_d;
    logic [15:0] drop_a, stall_a, flush_a, redir_a, fwd_a;
    logic [15:0] drop_b, stall_b, flush_b, redir_b, fwd_b;
    logic [15:0] drop_c, stall_c, flush_c, redir_c, fwd_c;
    logic [3:0]  drop_d, stall_d, flush_d, redir_d, fwd_d;
    logic [15:0] exp_ts [3];

    riscv_exec_trace_buf_if #(.XLEN(32), .TS_W(16)) if_a ();
    riscv_exec_trace_buf_if #(.XLEN(32), .TS_W(16)) if_b ();
    riscv_exec_trace_buf_if #(.XLEN(32), .TS_W(16)) if_c ();
    riscv_exec_trace_buf_if #(.XLEN(32), .TS_W(4))  if_d ();

    riscv_exec_trace_buf #(.MODE(0), .STALL_DEDUP(1)) u_a (
        .clk(clk), .rst_n(rst_n), .valid(valid), .instr(instr), .pc(pc),
        .forward_a(forward_a), .forward_b(forward_b), .stall_if(stall_if),
        .flush_ex(flush_ex), .redirect_valid(redirect_valid), .clear(clear), .rd(if_a.master),
        .count(count_a), .overflow(ovf_a), .drop_cnt(drop_a), .stall_cnt(stall_a),
        .flush_cnt(flush_a), .redir_cnt(redir_a), .fwd_cnt(fwd_a));
    riscv_exec_trace_buf #(.MODE(1), .STALL_DEDUP(1)) u_b (
        .clk(clk), .rst_n(rst_n), .valid(valid), .instr(instr), .pc(pc),
        .forward_a(forward_a), .forward_b(forward_b), .stall_if(stall_if),
        .flush_ex(flush_ex), .redirect_valid(redirect_valid), .clear(clear), .rd(if_b.master),
        .count(count_b), .overflow(ovf_b), .drop_cnt(drop_b), .stall_cnt(stall_b),
        .flush_cnt(flush_b), .redir_cnt(redir_b), .fwd_cnt(fwd_b));
    riscv_exec_trace_buf #(.MODE(0), .STALL_DEDUP(0)) u_c (
        .clk(clk), .rst_n(rst_n), .valid(valid), .instr(instr), .pc(pc),
        .forward_a(forward_a), .forward_b(forward_b), .stall_if(stall_if),
        .flush_ex(flush_ex), .redirect_valid(redirect_valid), .clear(clear), .rd(if_c.master),
        .count(count_c), .overflow(ovf_c), .drop_cnt(drop_c), .stall_cnt(stall_c),
        .flush_cnt(flush_c), .redir_cnt(redir_c), .fwd_cnt(fwd_c));
    riscv_exec_trace_buf #(.TS_W(4), .CNT_W(4)) u_d (
        .clk(clk), .rst_n(rst_n), .valid(valid), .instr(instr), .pc(pc),
        .forward_a(forward_a), .forward_b(forward_b), .stall_if(stall_if),
        .flush_ex(flush_ex), .redirect_valid(redirect_valid), .clear(clear), .rd(if_d.master),
        .count(count_d), .overflow(ovf_d), .drop_cnt(drop_d), .stall_cnt(stall_d),
        .flush_cnt(flush_d), .redir_cnt(redir_d), .fwd_cnt(fwd_d));

    always #5 clk = ~clk;

    // Reference cycle counter: equals the DUT timestamp between edges.
    always @(posedge clk) tcount <= rst_n ? tcount + 32'd1 : 32'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ex(input logic v, input logic [31:0] p, input logic [1:0] fa,
                      input logic [1:0] fb, input logic st, input logic fl, input logic rv);
        valid          = v;
        pc             = p;
        instr          = v ? 32'h00a0_0093 : 32'h0;
        forward_a      = fa;
        forward_b      = fb;
        stall_if       = st;
        flush_ex       = fl;
        redirect_valid = rv;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        if_a.rd_ready = 1'b0;
        if_b.rd_ready = 1'b0;
        if_c.rd_ready = 1'b0;
        if_d.rd_ready = 1'b0;
        ex(1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_rd_valid", if_a.rd_valid, 1'b0);
        chk("rst_count", count_a, 5'd0);
        chk("rst_overflow", ovf_a, 1'b0);
        chk("rst_rd_pc", if_a.rd_pc, 32'h0);
        chk("rst_drop", drop_a, 16'd0);
        rst_n = 1'b1;
        tick();

        // MODE=0 streaming with the reader always ready
        if_a.rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex(1'b1, 32'h100 + 32'(4 * i), 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
            exp_ts[i] = tcount[15:0];
            tick();
            chk("m0_valid", if_a.rd_valid, 1'b1);
            chk("m0_pc", if_a.rd_pc, 32'h100 + 32'(4 * i));
            chk("m0_ts", if_a.rd_ts, exp_ts[i]);
            chk("m0_flags", if_a.rd_flags, 7'h00);
        end
        chk("m0_instr", if_a.rd_instr, 32'h00a0_0093);
        chk("m0_ts_consecutive", exp_ts[2] - exp_ts[0], 16'd2);
        ex(1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        chk("m0_drained", if_a.rd_valid, 1'b0);
        chk("m0_count", count_a, 5'd0);
        chk("m0_fwd_cnt", fwd_a, 16'd0);

        // MODE=1 keeps only event cycles
        do_clear();
        for (int i = 0; i < 4; i++) begin
            ex(1'b1, 32'h180 + 32'(4 * i), (i == 1) ? 2'b01 : 2'b00, 2'b00,
               1'b0, 1'b0, (i == 3) ? 1'b1 : 1'b0);
            tick();
        end
        ex(1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("m1_count", count_b, 5'd2);
        chk("m1_head_pc", if_b.rd_pc, 32'h184);
        chk("m1_head_flags", if_b.rd_flags, 7'h01);
        chk("m1_redir_cnt", redir_b, 16'd1);
        chk("m1_fwd_cnt", fwd_b, 16'd1);
        if_b.rd_ready = 1'b1;
        tick();
        chk("m1_second_valid", if_b.rd_valid, 1'b1);
        chk("m1_second_pc", if_b.rd_pc, 32'h18c);
        chk("m1_second_flags", if_b.rd_flags, 7'h40);
        tick();
        chk("m1_empty", if_b.rd_valid, 1'b0);
        if_b.rd_ready = 1'b0;

        // Stall hold: dedup on (A) versus off (C)
        if_a.rd_ready = 1'b0;
        do_clear();
        for (int i = 0; i < 5; i++) begin
            ex(1'b1, 32'h200, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
            tick();
        end
        ex(1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("dedup_count", count_a, 5'd1);
        chk("dedup_stall_cnt", stall_a, 16'd5);
        chk("nodedup_count", count_c, 5'd5);
        tick();

        // Overflow: 20 captures into 16 entries
        do_clear();
        for (int i = 0; i < 20; i++) begin
            ex(1'b1, 32'h300 + 32'(4 * i), 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
            tick();
        end
        ex(1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("ovf_count", count_a, 5'd16);
        chk("ovf_flag", ovf_a, 1'b1);
        chk("ovf_drop_cnt", drop_a, 16'd4);
        chk("ovf_head_pc", if_a.rd_pc, 32'h300);

        // Full plus simultaneous pop: no drop, occupancy unchanged
        ex(1'b1, 32'h400, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1);
        if_a.rd_ready = 1'b1;
        tick();
        ex(1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        if_a.rd_ready = 1'b0;
        chk("fullpop_count", count_a, 5'd16);
        chk("fullpop_drop_cnt", drop_a, 16'd4);
        chk("fullpop_head_pc", if_a.rd_pc, 32'h304);
        chk("fullpop_stall_cnt", stall_a, 16'd1);
        chk("fullpop_redir_cnt", redir_a, 16'd1);
        if_a.rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_pc", if_a.rd_pc, (i < 15) ? 32'h304 + 32'(4 * i) : 32'h400);
            tick();
        end
        chk("drain_empty", if_a.rd_valid, 1'b0);
        if_a.rd_ready = 1'b0;
        chk("pre_clear_ovf", ovf_a, 1'b1);
        do_clear();
        chk("clr_count", count_a, 5'd0);
        chk("clr_overflow", ovf_a, 1'b0);
        chk("clr_drop", drop_a, 16'd0);
        chk("clr_stall", stall_a, 16'd0);
        chk("clr_flush", flush_a, 16'd0);
        chk("clr_redir", redir_a, 16'd0);
        chk("clr_fwd", fwd_a, 16'd0);

        // Counter saturation at CNT_W=4
        for (int i = 0; i < 20; i++) begin
            ex(1'b1, 32'h500, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
            tick();
        end
        ex(1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("sat_flush_cnt_d", flush_d, 4'd15);
        chk("flush_cnt_a", flush_a, 16'd20);

        // Timestamp wrap at TS_W=4: captures at ts 15 and 0
        do_clear();
        for (int k = 0; k < 16; k++) begin
            if (tcount[3:0] != 4'd15) tick();
        end
        ex(1'b1, 32'h600, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        ex(1'b1, 32'h604, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        ex(1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("wrap_count", count_d, 5'd2);
        chk("wrap_ts_first", if_d.rd_ts, 4'd15);
        chk("wrap_pc_first", if_d.rd_pc, 32'h600);
        if_d.rd_ready = 1'b1;
        tick();
        chk("wrap_ts_second", if_d.rd_ts, 4'd0);
        chk("wrap_pc_second", if_d.rd_pc, 32'h604);
        if_d.rd_ready = 1'b0;

        // Reset in the middle of a drain discards everything
        do_clear();
        for (int i = 0; i < 3; i++) begin
            ex(1'b1, 32'h700 + 32'(4 * i), 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
            tick();
        end
        ex(1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("mid_count", count_a, 5'd3);
        if_a.rd_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_count", count_a, 5'd0);
        chk("midrst_valid", if_a.rd_valid, 1'b0);
        chk("midrst_pc", if_a.rd_pc, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("postrst_valid", if_a.rd_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
